// File: rtl/tiny16_mem_pkg.sv
// tiny16_mem_pkg: shared widths, DMA state encoding and mode constants
package tiny16_mem_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_MEM_SIZE   = 256;
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    typedef enum logic [2:0] {IDLE, SRC, CAP, DST, WR, DONE} state_e;
endpackage

// File: rtl/mem_dma_if.sv
// mem_dma_if: memory control bus between an initiator (master) and the memory (slave)
interface mem_dma_if #(
    parameter int DATA_WIDTH = tiny16_mem_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = tiny16_mem_pkg::DEF_ADDR_WIDTH
);
    logic                  mem_addr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_in_en;
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  mem_out_en;
    logic [DATA_WIDTH-1:0] mem_out;
    modport master (output mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en, input mem_out);
    modport slave (input mem_addr_en, mem_addr, mem_in_en, mem_in, mem_out_en, output mem_out);
endinterface

// File: rtl/mem_dma.sv
// mem_dma: block copy / block fill engine driving the shared memory bus
module mem_dma
    import tiny16_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_SIZE   = DEF_MEM_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    mem_dma_if.master             bus
);
    localparam int SW = ADDR_WIDTH + 1;
    state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] sptr_q, sptr_d, dptr_q, dptr_d, cnt_q, cnt_d, step;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic mode_q, mode_d, desc_q, desc_d, err_q, err_d;
    logic [SW-1:0] src_end, dst_end;
    logic accept, bad, desc;
    assign src_end = {1'b0, src} + {1'b0, len};
    assign dst_end = {1'b0, dst} + {1'b0, len};
    assign bad     = dst_end > SW'(MEM_SIZE) || (mode == MODE_COPY && src_end > SW'(MEM_SIZE));
    // overlapping copy with dst above src must run top-down to avoid clobbering unread words
    assign desc    = mode == MODE_COPY && src < dst && {1'b0, dst} < src_end;
    assign accept  = state_q == IDLE && start && !err_q;
    assign step    = desc_q ? '1 : ADDR_WIDTH'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept || bad ? IDLE : len == '0 ? DONE : mode == MODE_FILL ? DST : SRC;
            SRC:     state_d = CAP;
            CAP:     state_d = WR;
            DST:     state_d = WR;
            WR:      state_d = cnt_q == ADDR_WIDTH'(1) ? DONE : mode_q == MODE_FILL ? DST : SRC;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sptr_q <= '0;
            dptr_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            mode_q <= 1'b0;
            desc_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sptr_q <= sptr_d;
            dptr_q <= dptr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            mode_q <= mode_d;
            desc_q <= desc_d;
            err_q  <= err_d;
        end
    end
    always_comb begin
        sptr_d = sptr_q;
        dptr_d = dptr_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        mode_d = mode_q;
        desc_d = desc_q;
        err_d  = accept && bad;
        if (accept && !bad) begin
            mode_d = mode;
            desc_d = desc;
            cnt_d  = len;
            sptr_d = desc ? src_end[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1) : src;
            dptr_d = desc ? dst_end[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1) : dst;
            // fill value parks in the data register; fill never overwrites it
            data_d = mode == MODE_FILL ? DATA_WIDTH'(src) : data_q;
        end
        if (state_q == CAP) data_d = bus.mem_out;
        if (state_q == WR) begin
            cnt_d  = cnt_q - ADDR_WIDTH'(1);
            sptr_d = sptr_q + step;
            dptr_d = dptr_q + step;
        end
    end
    always_comb begin
        busy            = state_q inside {SRC, CAP, DST, WR};
        done            = state_q == DONE;
        error           = err_q;
        bus.mem_addr_en = state_q inside {SRC, CAP, DST};
        bus.mem_addr    = state_q == SRC ? sptr_q : state_q inside {CAP, DST} ? dptr_q : '0;
        bus.mem_in_en   = state_q == WR;
        bus.mem_in      = state_q == WR ? data_q : '0;
        bus.mem_out_en  = state_q == CAP;
    end
endmodule
